// File: rtl/cont_seq_checker.sv
// Receive-side checker for a triangle counter stream (0..MAX..0..).
// Locks after LOCK_LEN legal steps, then flags every deviation from the expected next value.
module cont_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 3,
    parameter int ERR_W    = 8,
    parameter int PER_W    = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    input  logic             Valid,
    output logic             Locked,
    output logic             Dir,
    output logic             Err,
    output logic [ERR_W-1:0] ErrCount,
    output logic [PER_W-1:0] PeriodCount
);

    typedef enum logic {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
    localparam logic [3:0]       RUN_LOCK = 4'(LOCK_LEN);

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             cand_dir_q, cand_dir_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [PER_W-1:0] period_count_q, period_count_d;

    logic             step_up;
    logic             step_legal;
    logic             turnaround;
    logic             counting;
    logic [3:0]       run_inc;
    logic [WIDTH-1:0] expected;

    // Wrap steps (0->MAX, MAX->0) fail the magnitude test, so no explicit exclusion is needed.
    always_comb begin
        step_up    = (In > prev_q);
        step_legal = (step_up && (In == prev_q + ONE_VAL)) ||
                     (!step_up && (In == prev_q - ONE_VAL));
        turnaround = (prev_q == MAX_VAL && !step_up) || (prev_q == ZERO_VAL && step_up);
        counting   = step_legal && ((run_q == 4'd0) || (step_up == cand_dir_q) || turnaround);
        run_inc    = run_q + 4'd1;
        if (dir_q) begin
            expected = (prev_q == MAX_VAL) ? MAX_VAL - ONE_VAL : prev_q + ONE_VAL;
        end else begin
            expected = (prev_q == ZERO_VAL) ? ONE_VAL : prev_q - ONE_VAL;
        end
    end

    always_comb begin
        state_d        = state_q;
        run_d          = run_q;
        cand_dir_d     = cand_dir_q;
        prev_d         = prev_q;
        have_prev_d    = have_prev_q;
        dir_d          = dir_q;
        err_d          = 1'b0;
        err_count_d    = err_count_q;
        period_count_d = period_count_q;

        if (Valid) begin
            prev_d      = In;
            have_prev_d = 1'b1;
            if (have_prev_q) begin
                if (state_q == S_HUNT) begin
                    if (counting) begin
                        cand_dir_d = step_up;
                        if (run_inc == RUN_LOCK) begin
                            state_d = S_LOCKED;
                            dir_d   = step_up;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (step_legal) begin
                        // A legal step against the candidate restarts the run in its own direction.
                        cand_dir_d = step_up;
                        run_d      = 4'd1;
                    end else begin
                        run_d = 4'd0;
                    end
                end else begin
                    if (In == expected) begin
                        if (dir_q && prev_q == MAX_VAL) begin
                            dir_d = 1'b0;
                        end else if (!dir_q && prev_q == ZERO_VAL) begin
                            dir_d = 1'b1;
                        end
                        if (In == ZERO_VAL) begin
                            period_count_d = period_count_q + PER_W'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_HUNT;
                        run_d   = 4'd0;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= S_HUNT;
            run_q          <= 4'd0;
            cand_dir_q     <= 1'b1;
            prev_q         <= '0;
            have_prev_q    <= 1'b0;
            dir_q          <= 1'b1;
            err_q          <= 1'b0;
            err_count_q    <= '0;
            period_count_q <= '0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            cand_dir_q     <= cand_dir_d;
            prev_q         <= prev_d;
            have_prev_q    <= have_prev_d;
            dir_q          <= dir_d;
            err_q          <= err_d;
            err_count_q    <= err_count_d;
            period_count_q <= period_count_d;
        end
    end

    assign Locked      = (state_q == S_LOCKED);
    assign Dir         = dir_q;
    assign Err         = err_q;
    assign ErrCount    = err_count_q;
    assign PeriodCount = period_count_q;

endmodule

// File: tb/tb_cont_seq_checker.sv
// Directed bench for cont_seq_checker: a default instance plus a 2-bit error counter instance
// sharing the same stimulus.
module tb_cont_seq_checker;

    logic       clk;
    logic       rst;
    logic [3:0] in_val;
    logic       valid;

    logic       locked, dir, err;
    logic [7:0] err_count, period_count;
    logic       s_locked, s_dir, s_err;
    logic [1:0] s_err_count;
    logic [7:0] s_period_count;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    cont_seq_checker u_dut (
        .Clock(clk), .Reset(rst), .In(in_val), .Valid(valid),
        .Locked(locked), .Dir(dir), .Err(err),
        .ErrCount(err_count), .PeriodCount(period_count)
    );

    cont_seq_checker #(.ERR_W(2)) u_sat (
        .Clock(clk), .Reset(rst), .In(in_val), .Valid(valid),
        .Locked(s_locked), .Dir(s_dir), .Err(s_err),
        .ErrCount(s_err_count), .PeriodCount(s_period_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_val);
        checks++;
        if (obs != exp_val) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_val);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step(input logic v, input int x);
        valid  = v;
        in_val = 4'(x);
        @(posedge clk);
        #1;
        valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_dir"}, int'(dir), 1);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_errcnt"}, int'(err_count), 0);
        chk({tag, "_percnt"}, int'(period_count), 0);
    endtask

    initial begin
        rst    = 1'b0;
        valid  = 1'b0;
        in_val = 4'd0;

        // Reset state
        do_reset();
        chk_reset_state("reset");

        // Run-in and lock
        step(1, 0);
        step(1, 1);
        step(1, 2);
        chk("runin_not_locked", int'(locked), 0);
        chk("runin_err", int'(err), 0);
        step(1, 3);
        chk("lock_locked", int'(locked), 1);
        chk("lock_dir", int'(dir), 1);
        chk("lock_err", int'(err), 0);

        // Full period
        for (int i = 4; i <= 15; i++) begin
            step(1, i);
            chk($sformatf("up_%0d_err", i), int'(err), 0);
        end
        chk("at_max_dir", int'(dir), 1);
        step(1, 14);
        chk("turn_down_dir", int'(dir), 0);
        for (int i = 13; i >= 0; i--) begin
            step(1, i);
            chk($sformatf("down_%0d_err", i), int'(err), 0);
        end
        chk("period_count1", int'(period_count), 1);
        chk("period_errcnt", int'(err_count), 0);
        chk("period_locked", int'(locked), 1);
        step(1, 1);
        chk("turn_up_dir", int'(dir), 1);

        // Error and relock
        step(1, 2); step(1, 3); step(1, 4); step(1, 5);
        step(1, 9);
        chk("mis_err", int'(err), 1);
        chk("mis_errcnt", int'(err_count), 1);
        chk("mis_locked", int'(locked), 0);
        chk("mis_dir_hold", int'(dir), 1);
        step(0, 0);
        chk("mis_err_one_cycle", int'(err), 0);
        step(1, 10);
        step(1, 11);
        chk("relock_pending", int'(locked), 0);
        step(1, 12);
        chk("relock_locked", int'(locked), 1);
        chk("relock_dir", int'(dir), 1);

        // Valid gaps: In=7 while Valid=0 must be ignored
        step(1, 13);
        for (int g = 0; g < 3; g++) begin
            step(0, 7);
            chk($sformatf("gap%0d_err", g), int'(err), 0);
            chk($sformatf("gap%0d_locked", g), int'(locked), 1);
            chk($sformatf("gap%0d_errcnt", g), int'(err_count), 1);
        end
        step(1, 14);
        chk("gap_after_err", int'(err), 0);
        chk("gap_after_locked", int'(locked), 1);

        // Build ErrCount=3, PeriodCount=2 using repeated values as the errors
        step(1, 15);
        for (int i = 14; i >= 0; i--) step(1, i);
        chk("period_count2", int'(period_count), 2);
        step(1, 0);
        chk("repeat0_err", int'(err), 1);
        chk("repeat0_errcnt", int'(err_count), 2);
        chk("repeat0_locked", int'(locked), 0);
        step(1, 1); step(1, 2); step(1, 3);
        chk("relock2_locked", int'(locked), 1);
        step(1, 3);
        chk("repeat3_err", int'(err), 1);
        chk("repeat3_errcnt", int'(err_count), 3);
        step(1, 4); step(1, 5); step(1, 6);
        chk("relock3_locked", int'(locked), 1);
        chk("relock3_percnt", int'(period_count), 2);

        // Reset mid-run, with a simultaneous valid sample that must be discarded
        valid  = 1'b1;
        in_val = 4'd7;
        do_reset();
        valid  = 1'b0;
        chk_reset_state("midrst");
        step(1, 9);
        chk("first_sample_err", int'(err), 0);
        chk("first_sample_locked", int'(locked), 0);
        step(1, 10); step(1, 11); step(1, 12);
        chk("post_rst_lock", int'(locked), 1);
        chk("post_rst_errcnt", int'(err_count), 0);

        // Saturation: ERR_W=2 instance saturates at 3, default instance keeps counting
        do_reset();
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(1, 0);
            if (s_err) pulses++;
            step(1, 1);
            if (s_err) pulses++;
            step(1, 2);
            if (s_err) pulses++;
            step(1, 3);
            if (s_err) pulses++;
            chk($sformatf("sat%0d_locked", k), int'(s_locked), 1);
            step(1, 7);
            if (s_err) pulses++;
            chk($sformatf("sat%0d_err", k), int'(s_err), 1);
            chk($sformatf("sat%0d_errcnt", k), int'(s_err_count), (k + 1 > 3) ? 3 : k + 1);
            chk($sformatf("wide%0d_errcnt", k), int'(err_count), k + 1);
        end
        chk("sat_pulses", pulses, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cont_seq_checker.md
Name: cont_seq_checker

Overview:
- Receive-side monitor for the triangle counter stream (0, 1, ..., MAX-1, MAX, MAX-1, ..., 1, 0, 1, ...).
- Samples the counter value on qualified cycles, locks onto the sequence and tracks the count direction.
- Flags every departure from the expected next value and counts errors and completed periods.
- Sits at the consumer end of the counter output bus and is used as a protocol checker in simulation and in hardware self-test.

Parameters:
- WIDTH, 4: counter value width; MAX = 2^WIDTH - 1.
- LOCK_LEN, 3: consecutive legal steps required to enter lock, range 1..15.
- ERR_W, 8: width of the error counter.
- PER_W, 8: width of the period counter.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- In  input  WIDTH  counter value under check.
- Valid  input  1  In is sampled only when 1.
- Locked  output  1  1 = tracking the sequence.
- Dir  output  1  current direction: 1 = up, 0 = down.
- Err  output  1  one-cycle pulse, one per mismatching sample.
- ErrCount  output  ERR_W  saturating error total.
- PeriodCount  output  PER_W  completed 0->MAX->0 periods, wraps modulo 2^PER_W.

Behaviour:
- Reset and clock: Reset is synchronous, active-high, on Clock; Reset has priority over Valid.
- Reset values: Locked=0, Dir=1, Err=0, ErrCount=0, PeriodCount=0, state=HUNT, run=0, have_prev=0.
- Registered outputs: all outputs are registered. Effects of the sample taken at edge N are visible after edge N.
- Valid=0 cycles: all state held; Err=0.
- First sample: the first valid sample after reset sets Prev=In and have_prev=1. No check is made.
- Legal step: |In - Prev| == 1 with no modular wrap (0->MAX and MAX->0 are illegal). Step direction = sign of the difference.
- HUNT, legal step:
  - Counts toward lock if run==0, or the step direction equals the candidate direction, or it is a turnaround (Prev==MAX going down, or Prev==0 going up).
  - On a counting step: candidate direction = step direction; run++.
- HUNT, other cases: any other sample sets run=0, and run becomes 1 if the new step is itself legal.
- HUNT exit: when run reaches LOCK_LEN, go to LOCKED; Locked=1; Dir = candidate direction.
- LOCKED, expected value:
  - Dir=1: Prev==MAX ? MAX-1 : Prev+1.
  - Dir=0: Prev==0 ? 1 : Prev-1.
- LOCKED, match (In == expected):
  - Dir flips to 0 when In==MAX-1 after Prev==MAX; flips to 1 when In==1 after Prev==0.
  - PeriodCount increments when In==0 (a down arrival at 0).
- LOCKED, mismatch:
  - Err=1 for exactly one cycle; ErrCount increments, saturating at 2^ERR_W - 1.
  - State goes to HUNT; Locked=0; run=0.
  - Dir holds its last value.
- Errors in HUNT: none are counted.
- Prev update: Prev <= In on every valid sample, including bad ones. Resync starts from the offending value.
- Simultaneous Reset and Valid: Reset wins and the sample is discarded.
- Reset during LOCKED: everything returns to its reset value at the next edge. The first valid sample afterwards is unchecked.
- Repeated value (In==Prev): illegal; treated as a mismatch in LOCKED.

Test Plan:
- Run-in and lock: after Reset, feed valid 0,1,2,3 on consecutive cycles -> Locked=1 and Dir=1 the cycle after sample 3; Err stays 0.
- Full period: continue with 4..15 then 14..0 -> Dir=0 after sample 14, PeriodCount=1 after sample 0, ErrCount=0. Then feed 1 -> Dir=1.
- Error and relock: locked at 5, feed 9 -> Err high exactly one cycle, ErrCount=1, Locked=0. Then feed 10,11,12 -> Locked=1, Dir=1.
- Valid gaps: interleave 3 cycles of Valid=0 with In=7 between legal samples -> no state change, Err=0, counters unchanged.
- Reset mid-run: locked with ErrCount=3 and PeriodCount=2, assert Reset one cycle -> all outputs 0 except Dir=1. Then feed 9 -> no Err, since it is the first sample.
- Saturation with ERR_W=2: force 5 lock/mismatch cycles (each 0,1,2,3 then 7) -> ErrCount goes 1,2,3,3,3; Err pulses 5 times.
